processor_control_unit: RTL
===========================

PROCESSOR_CONTROL_UNIT -- requirements
Module: processor_control_unit

Interface
REQ-001 SHALL have: Clk  input  1  rising-edge clock.
REQ-002 SHALL have: Resetn  input  1  reset, synchronous, active-low; clock Clk.
REQ-003 SHALL have: Run  input  1  start request; sampled only in IDLE.
REQ-004 SHALL have: DIN  input  8  instruction word (IDLE) / immediate data (mvi T1).
REQ-005 SHALL have: S  output  5  one-hot bus select: bit0 R0, bit1 R1, bit2 R2, bit3 R3, bit4 DIN; 00000 = no register source.
REQ-006 SHALL have: R0in, R1in, R2in, R3in  output  1 each  register load enables.
REQ-007 SHALL have: Ain  output  1  ALU operand-A register load enable.
REQ-008 SHALL have: Gin  output  1  ALU result register G load enable.
REQ-009 SHALL have: Gout  output  1  G drives bus; asserted only with S = 00000.
REQ-010 SHALL have: AddSub  output  1  0 = add, 1 = subtract; meaningful only with Gin.
REQ-011 SHALL have: Done  output  1  one-cycle pulse in final cycle of an instruction.
REQ-012 SHALL have: IR  output  8  current instruction register contents.

Function
REQ-013 Instruction format SHALL be: IR[7:5] opcode, IR[4:3] Rx, IR[2:1] Ry, IR[0] ignored.
REQ-014 Opcodes SHALL be: 000 mv Rx<-Ry; 001 mvi Rx<-DIN; 010 add Rx<-Rx+Ry; 011 sub Rx<-Rx-Ry; 100-111 nop.
REQ-015 FSM states SHALL be IDLE, T1, T2, T3; state and IR registered, all other outputs combinational from state and IR.
REQ-016 IDLE: all control outputs SHALL be 0 (S = 00000); if Run = 1, IR <= DIN and next = T1, else remain IDLE with IR held.
REQ-017 mv in T1: S = onehot(Ry), Rxin = 1, Done = 1, next IDLE.
REQ-018 mvi in T1: S = 10000, Rxin = 1, Done = 1, next IDLE; DIN must carry data this cycle.
REQ-019 add/sub T1: S = onehot(Rx), Ain = 1, next T2.
REQ-020 add/sub T2: S = onehot(Ry), Gin = 1, AddSub = IR[5], next T3.
REQ-021 add/sub T3: S = 00000, Gout = 1, Rxin = 1, Done = 1, next IDLE.
REQ-022 nop in T1: Done = 1 only, no enables, S = 00000, next IDLE.
REQ-023 At most one of R0in..R3in SHALL be 1 in any cycle; S SHALL be one-hot or 00000.
REQ-024 Rx = Ry (e.g. mv R1,R1; add R2,R2) SHALL execute normally, no special case.
REQ-025 Run SHALL be ignored outside IDLE; IR SHALL not change outside IDLE.
REQ-026 Run held high SHALL start the next instruction on the cycle after Done (IDLE cycle loads new IR); minimum 2 cycles per mv/mvi/nop, 4 per add/sub.

Reset
REQ-027 On Clk edge with Resetn = 0: state <= IDLE, IR <= 8'h00; all other outputs 0 in the following cycle.
REQ-028 Reset SHALL override Run and any in-progress instruction; no enable or Done asserted after the reset edge until a new Run.

Verification
REQ-029 Reset, then Run=1 DIN=0x12 (mv R2,R1) -> IR=0x12; next cycle S=00010, R2in=1, Done=1; then IDLE, all 0.
REQ-030 Run=1 DIN=0x38 (mvi R3), then DIN=0xA5 -> T1: S=10000, R3in=1, Done=1.
REQ-031 Run=1 DIN=0x42 (add R0,R1) -> T1 S=00001 Ain=1; T2 S=00010 Gin=1 AddSub=0; T3 S=00000 Gout=1 R0in=1 Done=1.
REQ-032 Run=1 DIN=0x6C (sub R1,R2) -> T2 S=00100 Gin=1 AddSub=1; T3 Gout=1 R1in=1 Done=1; Run toggled during T1-T3 has no effect, IR stays 0x6C.
REQ-033 Start add 0x42, assert Resetn=0 in T2 -> next cycle IDLE, IR=0x00, Gout/R0in/Done never asserted.
REQ-034 Run=1 DIN=0xE0 (nop) -> T1 Done=1, S=00000, all enables 0; Run held high -> back-to-back instruction loaded on following IDLE cycle.

Source files
------------

// File: rtl/processor_control_unit_if.sv
// Control-unit bus: Run/DIN flow into the control unit; the datapath enables, the bus select and IR flow out.
interface processor_control_unit_if;
    logic       Run;
    logic [7:0] DIN;
    logic [4:0] S;
    logic       R0in;
    logic       R1in;
    logic       R2in;
    logic       R3in;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       AddSub;
    logic       Done;
    logic [7:0] IR;

    modport master (
        output Run, DIN,
        input  S, R0in, R1in, R2in, R3in, Ain, Gin, Gout, AddSub, Done, IR
    );

    modport slave (
        input  Run, DIN,
        output S, R0in, R1in, R2in, R3in, Ain, Gin, Gout, AddSub, Done, IR
    );
endinterface

// File: rtl/processor_control_unit.sv
// Multi-cycle control unit for a 4-register processor (mv, mvi, add, sub, nop).
// Only the state and IR are registered; every datapath control is decoded from them.
module processor_control_unit (
    input  logic                          Clk,
    input  logic                          Resetn,
    processor_control_unit_if.slave       bus
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t     state, next_state;
    logic [7:0] ir_q;
    logic [2:0] opcode;
    logic [1:0] rx, ry;
    logic [4:0] sel;
    logic [3:0] rin;
    logic       ain, gin, gout, addsub, done;

    assign opcode = ir_q[7:5];
    assign rx     = ir_q[4:3];
    assign ry     = ir_q[2:1];

    function automatic logic [4:0] reg_select(input logic [1:0] r);
        reg_select = 5'b00001 << r;
    endfunction

    function automatic logic [3:0] reg_enable(input logic [1:0] r);
        reg_enable = 4'b0001 << r;
    endfunction

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state <= IDLE;
            ir_q  <= 8'h00;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.Run)
                ir_q <= bus.DIN;
        end
    end

    // T2 and T3 are only ever entered by add/sub, so they need no opcode decode.
    always_comb begin
        next_state = state;
        sel        = 5'b00000;
        rin        = 4'b0000;
        ain        = 1'b0;
        gin        = 1'b0;
        gout       = 1'b0;
        addsub     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Run)
                    next_state = T1;
            end
            T1: begin
                case (opcode)
                    3'b000: begin
                        sel        = reg_select(ry);
                        rin        = reg_enable(rx);
                        done       = 1'b1;
                        next_state = IDLE;
                    end
                    3'b001: begin
                        sel        = 5'b10000;
                        rin        = reg_enable(rx);
                        done       = 1'b1;
                        next_state = IDLE;
                    end
                    3'b010, 3'b011: begin
                        sel        = reg_select(rx);
                        ain        = 1'b1;
                        next_state = T2;
                    end
                    default: begin
                        done       = 1'b1;
                        next_state = IDLE;
                    end
                endcase
            end
            T2: begin
                sel        = reg_select(ry);
                gin        = 1'b1;
                addsub     = ir_q[5];
                next_state = T3;
            end
            T3: begin
                gout       = 1'b1;
                rin        = reg_enable(rx);
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.S      = sel;
    assign bus.R0in   = rin[0];
    assign bus.R1in   = rin[1];
    assign bus.R2in   = rin[2];
    assign bus.R3in   = rin[3];
    assign bus.Ain    = ain;
    assign bus.Gin    = gin;
    assign bus.Gout   = gout;
    assign bus.AddSub = addsub;
    assign bus.Done   = done;
    assign bus.IR     = ir_q;

endmodule
